conv1d_stream_par: RTL

Parametrised 1-D valid-mode convolution layer with a streamed, reloadable filter, P parallel MAC lanes, saturating output and optional ReLU. It is the successor to the fixed-ROM, single-MAC layer blocks in the layer pipeline. It sits between two AXI-stream-style stages: it consumes an x vector and a filter vector, and produces SIZE = LENX−LENF+1 outputs per x vector.

---
 rtl/conv1d_stream_par.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/conv1d_stream_par.sv
// Streamed 1-D valid-mode convolution: reloadable filter, P parallel MAC lanes,
// saturating output with optional ReLU, valid/ready on every port.
module conv1d_stream_par #(
  parameter int WIDTH = 16,
  parameter int LENX  = 24,
  parameter int LENF  = 10,
  parameter int P     = 2,
  parameter int RELU  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] s_data_in_x,
  input  logic             s_valid_x,
  output logic             s_ready_x,
  input  logic [WIDTH-1:0] s_data_in_f,
  input  logic             s_valid_f,
  output logic             s_ready_f,
  output logic [WIDTH-1:0] m_data_out_y,
  output logic             m_valid_y,
  input  logic             m_ready_y
);
  localparam int SIZE = LENX - LENF + 1;
  localparam int AW   = 2*WIDTH + $clog2(LENF);
  localparam int CW   = $clog2(LENX + 2);
  localparam int GW   = $clog2(SIZE + 1);
  localparam int LW   = $clog2(P + 1);
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {F_LOAD, WAIT, X_LOAD, CONV, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [GW-1:0]   g_q, g_d;
  logic [LW-1:0]   lane_q, lane_d;
  logic            acc_clr;
  logic            last_out;

  logic signed [WIDTH-1:0]   x_q    [LENX];
  logic signed [WIDTH-1:0]   f_q    [LENF];
  logic signed [2*WIDTH-1:0] prod_q [P];
  logic signed [AW-1:0]      acc_q  [P];
  logic signed [WIDTH-1:0]   xs     [P];
  logic signed [WIDTH-1:0]   fs;
  logic signed [AW-1:0]      acc_sel;

  function automatic logic signed [WIDTH-1:0] sat_relu(input logic signed [AW-1:0] a);
    logic signed [WIDTH-1:0] r;
    if (a > SAT_MAX)      r = SAT_MAX[WIDTH-1:0];
    else if (a < SAT_MIN) r = SAT_MIN[WIDTH-1:0];
    else                  r = a[WIDTH-1:0];
    if (RELU != 0 && r < 0) r = '0;
    return r;
  endfunction

  assign s_ready_f = reset && (state_q == F_LOAD);
  assign s_ready_x = reset && (state_q == X_LOAD);
  assign m_valid_y = reset && (state_q == DRAIN);
  assign last_out  = (int'(g_q) * P + int'(lane_q)) >= (SIZE - 1);

  always_comb begin
    acc_sel = acc_q[0];
    for (int p = 0; p < P; p++)
      if (LW'(p) == lane_q) acc_sel = acc_q[p];
  end
  assign m_data_out_y = m_valid_y ? sat_relu(acc_sel) : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    g_d     = g_q;
    lane_d  = lane_q;
    acc_clr = 1'b0;
    case (state_q)
      F_LOAD: if (s_valid_f) begin
        if (cnt_q == CW'(LENF - 1)) begin
          state_d = WAIT;
          cnt_d   = '0;
        end else cnt_d = cnt_q + CW'(1);
      end
      WAIT: begin
        cnt_d = '0;
        if (s_valid_f)      state_d = F_LOAD;
        else if (s_valid_x) state_d = X_LOAD;
      end
      X_LOAD: if (s_valid_x) begin
        if (cnt_q == CW'(LENX - 1)) begin
          state_d = CONV;
          cnt_d   = '0;
          g_d     = '0;
          acc_clr = 1'b1;
        end else cnt_d = cnt_q + CW'(1);
      end
      CONV: begin
        if (cnt_q == CW'(LENF)) begin
          state_d = DRAIN;
          cnt_d   = '0;
          lane_d  = '0;
        end else cnt_d = cnt_q + CW'(1);
      end
      DRAIN: if (m_ready_y) begin
        if (last_out) begin
          state_d = WAIT;
          g_d     = '0;
        end else if (lane_q == LW'(P - 1)) begin
          state_d = CONV;
          g_d     = g_q + GW'(1);
          cnt_d   = '0;
          acc_clr = 1'b1;
        end else lane_d = lane_q + LW'(1);
      end
      default: state_d = F_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= F_LOAD;
      cnt_q   <= '0;
      g_q     <= '0;
      lane_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      g_q     <= g_d;
      lane_q  <= lane_d;
    end
  end

  // Operand select: lane base index clamped so partial-group lanes stay inside x.
  always_comb begin
    int base;
    int idx;
    fs = '0;
    for (int i = 0; i < LENF; i++)
      if (CW'(i) == cnt_q) fs = f_q[i];
    for (int p = 0; p < P; p++) begin
      base = int'(g_q) * P + p;
      if (base > SIZE - 1) base = SIZE - 1;
      idx   = base + int'(cnt_q);
      xs[p] = '0;
      for (int i = 0; i < LENX; i++)
        if (i == idx) xs[p] = x_q[i];
    end
  end

  // Storage writes, product stage, then accumulate one cycle behind.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LENF; i++)
      if (s_ready_f && s_valid_f && cnt_q == CW'(i)) f_q[i] <= s_data_in_f;
    for (int i = 0; i < LENX; i++)
      if (s_ready_x && s_valid_x && cnt_q == CW'(i)) x_q[i] <= s_data_in_x;
    for (int p = 0; p < P; p++) begin
      if (state_q == CONV) begin
        prod_q[p] <= (2*WIDTH)'(xs[p]) * (2*WIDTH)'(fs);
        if (cnt_q != '0) acc_q[p] <= acc_q[p] + AW'(prod_q[p]);
      end
      if (acc_clr) acc_q[p] <= '0;
    end
  end
endmodule
